multicycle_controlpath: RTL
===========================

Name: multicycle_controlpath

Overview:
Multicycle control FSM for the RV32I-subset core. It sequences fetch/decode/execute/memory/writeback and drives the datapath strobes. It produces the 4-bit ALUOp consumed directly by the ALU-control stage: 1 = R/I arithmetic decode, 2 = branch compare (SUB), 3 = address/PC add. It also handles the memory ready handshake, a wait-state watchdog and a retired-instruction counter.

Parameters:
WAIT_MAX, 15, maximum cycles mem_ready may stay low in one memory state before abort.
CNT_W, 32, width of instret counter.

Ports:
clk  in  1  core clock.
rst_n  in  1  asynchronous active-low reset.
opcode  in  7  instr[6:0] from IR.
funct3_0  in  1  instr[12]; 0 = BEQ, 1 = BNE.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current access this cycle.
ALUOp  out  4  to ALU control.
mem_req  out  1  memory access request.
mem_we  out  1  write qualifier, valid with mem_req.
IorD  out  1  0 = PC address, 1 = ALUOut address.
IRWrite  out  1  load IR.
PCWrite  out  1  load PC.
PCSource  out  2  0 = ALU result, 1 = ALUOut (branch/jump target).
ALUSrcA  out  1  0 = PC, 1 = rs1.
ALUSrcB  out  2  0 = rs2, 1 = const 4, 2 = imm.
RegWrite  out  1  register-file write.
MemtoReg  out  2  0 = ALUOut, 1 = MDR, 2 = PC (link).
mem_timeout  out  1  sticky watchdog flag.
instret  out  CNT_W  retired instruction count.

Behaviour:
- State register is reset asynchronously to BOOT. mem_timeout and instret reset to 0.
- Outputs are decoded combinationally from state, and from mem_ready/zero where noted. In BOOT all strobes are 0, ALUOp = 0, and selects are 0.
- BOOT: all outputs idle. Go to FETCH unconditionally after 1 cycle.
- FETCH:
  - mem_req = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALUOp = 3.
  - While mem_ready = 0: stay, no strobes.
  - On mem_ready = 1: IRWrite = 1, PCWrite = 1, PCSource = 0, then go to DECODE.
- DECODE: ALUSrcA = 0, ALUSrcB = 2, ALUOp = 3 (target to ALUOut). Branch on opcode:
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 0000011 / 0100011 -> MEM_ADDR.
  - 1100011 -> BRANCH.
  - 1101111 -> JAL.
  - Anything else -> ILLEGAL.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 0, ALUOp = 1 -> ALU_WB.
- EXEC_I: as EXEC_R but ALUSrcB = 2 -> ALU_WB.
- ALU_WB: RegWrite = 1, MemtoReg = 0, instret += 1 -> FETCH.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 2, ALUOp = 3. Go to MEM_READ if opcode is LOAD, else MEM_WRITE.
- MEM_READ: mem_req = 1, IorD = 1; wait for mem_ready -> MEM_WB.
- MEM_WB: RegWrite = 1, MemtoReg = 1, instret += 1 -> FETCH.
- MEM_WRITE: mem_req = 1, mem_we = 1, IorD = 1. On mem_ready: instret += 1 -> FETCH.
- BRANCH:
  - ALUSrcA = 1, ALUSrcB = 0, ALUOp = 2, PCSource = 1.
  - PCWrite = zero ^ funct3_0.
  - instret += 1 -> FETCH.
- JAL: PCWrite = 1, PCSource = 1, RegWrite = 1, MemtoReg = 2, instret += 1 -> FETCH.
- Watchdog:
  - A counter clears on entry to FETCH/MEM_READ/MEM_WRITE and increments each cycle mem_ready = 0 in those states.
  - When the counter reaches WAIT_MAX with mem_ready still 0: set mem_timeout (sticky until reset), drop mem_req next cycle, and return to FETCH with the counter cleared. No strobes fire and instret is unchanged.
  - mem_ready = 1 on the same cycle the limit is hit wins: the access completes normally.
- instret wraps modulo 2^CNT_W.
- Reset asserted mid-instruction: state goes to BOOT and all strobes drop asynchronously. instret and mem_timeout clear.
- ILLEGAL: see optional feature.

Optional Feature:
CTRL_TRAP_EN.
- Defined: ILLEGAL is terminal. It asserts an extra output illegal_instr = 1 with all strobes 0, and is left only by reset.
- Undefined: illegal_instr port is absent. ILLEGAL acts as a NOP: 1 cycle, instret += 1, -> FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state enum.
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL.
  - ALUOp constants: ALUOP_ARITH = 1, ALUOP_BRANCH = 2, ALUOP_ADD = 3.
  - ALUSrcB, PCSource and MemtoReg select encodings.
- One sub-module, ctrl_out_decode: purely combinational state + mem_ready + zero + funct3_0 -> control word. The FSM, watchdog and counter stay in the top module.

Test Plan:
- ADDI, mem_ready tied 1: states BOOT, FETCH, DECODE, EXEC_I, ALU_WB. ALUOp = 1 in EXEC_I, RegWrite in cycle 5, instret = 1.
- LW with mem_ready low 3 cycles in MEM_READ: mem_req held 4 cycles, MEM_WB follows, RegWrite with MemtoReg = 1, instret += 1.
- BNE: zero = 0 -> PCWrite = 1 in BRANCH. zero = 1 -> PCWrite = 0. ALUOp = 2 in both cases.
- FETCH with mem_ready held 0 and WAIT_MAX = 15: mem_timeout rises after 15 wait cycles. FSM re-enters FETCH, instret unchanged, no IRWrite.
- Opcode 7'h7F: with CTRL_TRAP_EN, illegal_instr = 1 and the FSM stays there 20 cycles. Without it, the FSM returns to FETCH and instret += 1.
- rst_n pulsed low during MEM_WRITE: mem_req and mem_we drop immediately, instret = 0, FSM goes BOOT then FETCH.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control path.
// Holds the state encoding, RV32I opcode constants, ALUOp codes, datapath select
// encodings and the packed control word passed from the output decoder to the top.
package ctrl_pkg;

  // FSM state encoding (plain constants for compatibility with legacy tools).
  typedef logic [3:0] state_t;
  localparam state_t StBoot     = 4'd0;
  localparam state_t StFetch    = 4'd1;
  localparam state_t StDecode   = 4'd2;
  localparam state_t StExecR    = 4'd3;
  localparam state_t StExecI    = 4'd4;
  localparam state_t StAluWb    = 4'd5;
  localparam state_t StMemAddr  = 4'd6;
  localparam state_t StMemRead  = 4'd7;
  localparam state_t StMemWb    = 4'd8;
  localparam state_t StMemWrite = 4'd9;
  localparam state_t StBranch   = 4'd10;
  localparam state_t StJal      = 4'd11;
  localparam state_t StIllegal  = 4'd12;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALUOP_NONE   = 4'd0;
  localparam logic [3:0] ALUOP_ARITH  = 4'd1;
  localparam logic [3:0] ALUOP_BRANCH = 4'd2;
  localparam logic [3:0] ALUOP_ADD    = 4'd3;

  localparam logic       SRCA_PC  = 1'b0;
  localparam logic       SRCA_RS1 = 1'b1;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       retire;      // instruction completes at the end of this cycle
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_controlpath_if.sv
// Memory request/ready handshake between the control path and the memory.
//   mem_req   : access request from the controller
//   mem_we    : write qualifier, valid with mem_req
//   mem_ready : memory completes the current access this cycle
interface multicycle_controlpath_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

// File: rtl/ctrl_out_decode.sv
// Purely combinational control-word decoder for the multicycle control path.
//   state        : current FSM state
//   mem_ready    : memory handshake completion
//   zero         : ALU zero flag (branch resolution)
//   funct3_0     : 0 = BEQ, 1 = BNE
//   ctrl         : datapath strobes/selects plus a retire pulse
//   illegal      : only with CTRL_TRAP_EN, high while parked in ILLEGAL
module ctrl_out_decode
  import ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  input  logic       funct3_0,
  output ctrl_word_t ctrl
`ifdef CTRL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  always_comb begin
    ctrl = '0;
`ifdef CTRL_TRAP_EN
    illegal = 1'b0;
`endif
    case (state)
      StFetch: begin
        ctrl.mem_req   = 1'b1;
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        if (mem_ready) begin
          ctrl.ir_write  = 1'b1;
          ctrl.pc_write  = 1'b1;
          ctrl.pc_source = PCSRC_ALU;
        end
      end
      StDecode: begin
        // Precompute branch/jump target into ALUOut.
        ctrl.alu_src_a = SRCA_PC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StExecR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_ARITH;
      end
      StExecI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ARITH;
      end
      StAluWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_ALUOUT;
        ctrl.retire     = 1'b1;
      end
      StMemAddr: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      StMemRead: begin
        ctrl.mem_req = 1'b1;
        ctrl.iord    = 1'b1;
      end
      StMemWb: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_MDR;
        ctrl.retire     = 1'b1;
      end
      StMemWrite: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.iord    = 1'b1;
        ctrl.retire  = mem_ready;
      end
      StBranch: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_BRANCH;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = zero ^ funct3_0;  // taken: BEQ on zero, BNE on !zero
        ctrl.retire    = 1'b1;
      end
      StJal: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_ALUOUT;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = M2R_PC;
        ctrl.retire     = 1'b1;
      end
      StIllegal: begin
`ifdef CTRL_TRAP_EN
        illegal = 1'b1;
`else
        ctrl.retire = 1'b1;  // executes as a NOP
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controlpath.sv
// Multicycle FSM controller for the RV32I-subset core.
// Sequences fetch/decode/execute/memory/writeback, runs a memory wait-state
// watchdog and counts retired instructions.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   opcode, funct3_0  : instruction fields from IR
//   zero              : ALU zero flag
//   mem               : memory handshake (master side)
//   ALUOp .. MemtoReg : datapath strobes and selects
//   mem_timeout       : sticky watchdog flag
//   instret           : retired instruction count (wraps)
//   illegal_instr     : present only when CTRL_TRAP_EN is defined
// Build option: CTRL_TRAP_EN makes ILLEGAL a terminal trap state.
module multicycle_controlpath
  import ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [6:0]                 opcode,
  input  logic                       funct3_0,
  input  logic                       zero,
  multicycle_controlpath_if.master   mem,
  output logic [3:0]                 ALUOp,
  output logic                       IorD,
  output logic                       IRWrite,
  output logic                       PCWrite,
  output logic [1:0]                 PCSource,
  output logic                       ALUSrcA,
  output logic [1:0]                 ALUSrcB,
  output logic                       RegWrite,
  output logic [1:0]                 MemtoReg,
  output logic                       mem_timeout,
  output logic [CNT_W-1:0]           instret
`ifdef CTRL_TRAP_EN
  ,
  output logic                       illegal_instr
`endif
);

  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);
  // Counter holds completed wait cycles; the current one is the last allowed.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX - 1);

  state_t           state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic             timeout_q;
  logic [CNT_W-1:0] instret_q;
  ctrl_word_t       ctrl;
  logic             mem_state;
  logic             wait_limit;

  ctrl_out_decode u_decode (
    .state     (state_q),
    .mem_ready (mem.mem_ready),
    .zero      (zero),
    .funct3_0  (funct3_0),
    .ctrl      (ctrl)
`ifdef CTRL_TRAP_EN
    ,
    .illegal   (illegal_instr)
`endif
  );

  assign mem_state  = (state_q == StFetch) || (state_q == StMemRead) ||
                      (state_q == StMemWrite);
  // A ready on the limit cycle still completes the access.
  assign wait_limit = mem_state && !mem.mem_ready && (wait_cnt_q == WaitLast);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: begin
        if (mem.mem_ready)   state_d = StDecode;
        else if (wait_limit) state_d = StFetch;
      end
      StDecode: begin
        case (opcode)
          OP_R:               state_d = StExecR;
          OP_I:               state_d = StExecI;
          OP_LOAD, OP_STORE:  state_d = StMemAddr;
          OP_BRANCH:          state_d = StBranch;
          OP_JAL:             state_d = StJal;
          default:            state_d = StIllegal;
        endcase
      end
      StExecR, StExecI: state_d = StAluWb;
      StMemAddr:  state_d = (opcode == OP_LOAD) ? StMemRead : StMemWrite;
      StMemRead: begin
        if (mem.mem_ready)   state_d = StMemWb;
        else if (wait_limit) state_d = StFetch;
      end
      StMemWrite: begin
        if (mem.mem_ready || wait_limit) state_d = StFetch;
      end
      StAluWb, StMemWb, StBranch, StJal: state_d = StFetch;
`ifdef CTRL_TRAP_EN
      StIllegal: state_d = StIllegal;
`else
      StIllegal: state_d = StFetch;
`endif
      default: state_d = StBoot;
    endcase
  end

  // Clearing whenever not actively waiting also covers entry into a memory state.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !mem.mem_ready && !wait_limit) wait_cnt_d = wait_cnt_q + WaitW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_q | wait_limit;
      instret_q  <= instret_q + CNT_W'(ctrl.retire);
    end
  end

  assign mem.mem_req  = ctrl.mem_req;
  assign mem.mem_we   = ctrl.mem_we;
  assign ALUOp        = ctrl.alu_op;
  assign IorD         = ctrl.iord;
  assign IRWrite      = ctrl.ir_write;
  assign PCWrite      = ctrl.pc_write;
  assign PCSource     = ctrl.pc_source;
  assign ALUSrcA      = ctrl.alu_src_a;
  assign ALUSrcB      = ctrl.alu_src_b;
  assign RegWrite     = ctrl.reg_write;
  assign MemtoReg     = ctrl.mem_to_reg;
  assign mem_timeout  = timeout_q;
  assign instret      = instret_q;

endmodule
